// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: redirect input, imem request/grant/response, decode handshake.
interface fetch_unit_if;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        instValid;
   logic [31:0] instData;
   logic [31:0] instPC;
   logic        instFault;
   logic        instReady;
   logic [31:0] fetchPC;

   // fetch unit side
   modport master (
      input  redirect, redirectPC, imemGnt, imemRvalid, imemRdata, instReady,
      output imemReq, imemAddr, instValid, instData, instPC, instFault, fetchPC
   );

   // memory / decode / next-PC side
   modport slave (
      output redirect, redirectPC, imemGnt, imemRvalid, imemRdata, instReady,
      input  imemReq, imemAddr, instValid, instData, instPC, instFault, fetchPC
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding imem
// requests and buffers returned words with their PC for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect halts fetch and
// delivers one fault entry; when undefined, redirect targets are word-aligned.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 3
) (
   input logic          clk,
   input logic          rstn,
   fetch_unit_if.master bus
);
   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0] buf_pc_q   [BUF_DEPTH];
   logic [31:0] buf_data_q [BUF_DEPTH];

   logic             issue, push, pop, space, inst_valid;
   logic [31:0]      push_pc, push_data, redir_pc;
   logic [OCC_W-1:0] occupancy;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic buf_fault_q [BUF_DEPTH];
   logic halt_q, halt_d;
   logic fault_pend_q, fault_pend_d;
   logic push_fault;

   assign redir_pc = bus.redirectPC;
`else
   assign redir_pc = bus.redirectPC & 32'hFFFF_FFFC;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign inst_valid = (count_q != '0);

   // Next-state: request issue, response handling, redirect flush, buffer pointers
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      push       = 1'b0;
      pop        = 1'b0;
      push_pc    = req_pc_q;
      push_data  = bus.imemRdata;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_d       = halt_q;
      fault_pend_d = fault_pend_q;
      push_fault   = 1'b0;
`endif
      occupancy = OCC_W'(count_q) + OCC_W'(state_q != S_IDLE);
      space     = (occupancy < OCC_W'(BUF_DEPTH));
      issue     = !bus.redirect && space &&
                  ((state_q == S_IDLE) || ((state_q == S_WAIT) && bus.imemRvalid));
`ifdef FETCH_MISALIGN_CHECK_EN
      if (halt_q) issue = 1'b0;
`endif

      if (bus.redirect) begin
         fetch_pc_d = redir_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // an outstanding request becomes stale unless its response is here now
         if (state_q != S_IDLE) state_d = bus.imemRvalid ? S_IDLE : S_DROP;
`ifdef FETCH_MISALIGN_CHECK_EN
         halt_d       = (redir_pc[1:0] != 2'b00);
         fault_pend_d = (redir_pc[1:0] != 2'b00);
`endif
      end else begin
         pop = inst_valid && bus.instReady;
         if (bus.imemRvalid && (state_q != S_IDLE)) state_d = S_IDLE;
         if (bus.imemRvalid && (state_q == S_WAIT)) push = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
         // fault entry goes in once the stale response (if any) has drained
         if (fault_pend_q && (state_q == S_IDLE)) begin
            push         = 1'b1;
            push_pc      = fetch_pc_q;
            push_data    = '0;
            push_fault   = 1'b1;
            fault_pend_d = 1'b0;
         end
`endif
         if (issue && bus.imemGnt) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
         end
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         halt_q       <= 1'b0;
         fault_pend_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         halt_q       <= halt_d;
         fault_pend_q <= fault_pend_d;
`endif
      end
   end

   // Buffer payload storage; contents are only meaningful below count_q
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[wr_ptr_q]    <= push_pc;
         buf_data_q[wr_ptr_q]  <= push_data;
`ifdef FETCH_MISALIGN_CHECK_EN
         buf_fault_q[wr_ptr_q] <= push_fault;
`endif
      end
   end

   assign bus.imemReq   = issue;
   assign bus.imemAddr  = fetch_pc_q;
   assign bus.fetchPC   = fetch_pc_q;
   assign bus.instValid = inst_valid;
   assign bus.instData  = buf_data_q[rd_ptr_q];
   assign bus.instPC    = buf_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_CHECK_EN
   assign bus.instFault = inst_valid && buf_fault_q[rd_ptr_q];
`else
   assign bus.instFault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: random-latency memory model plus a stream model
// (decode must see consecutive PCs from the last redirect target, each with the
// memory word of that PC). Honours FETCH_MISALIGN_CHECK_EN like the design.
`timescale 1ns/1ps
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int unsigned DEPTH  = 3;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // stimulus controls
   logic        drv_redirect;
   logic [31:0] drv_target;
   logic        drv_ready;
   int unsigned gnt_pct;
   int unsigned lat_min;
   int unsigned lat_max;

   // memory model
   logic        mem_pending;
   logic [31:0] mem_addr;
   int unsigned mem_wait;

   // observations of the current cycle
   logic        o_req, o_valid, o_fault, o_pop, o_grant, o_rvalid;
   logic [31:0] o_addr, o_pc, o_data, o_fetch;

   // stream model
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rstn            = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirectPC  = '0;
      bus.imemGnt     = 1'b0;
      bus.imemRvalid  = 1'b0;
      bus.imemRdata   = '0;
      bus.instReady   = 1'b0;
      mem_pending     = 1'b0;
      drv_redirect    = 1'b0;
      drv_target      = '0;
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      exp_pc = RST_PC;
   endtask

   // one clock: drive inputs, let comb settle, sample, then answer the request
   task automatic step();
      @(negedge clk);
      bus.redirect   = drv_redirect;
      bus.redirectPC = drv_target;
      bus.instReady  = drv_ready;
      if (mem_pending && mem_wait == 0) begin
         bus.imemRvalid = 1'b1;
         bus.imemRdata  = mem_word(mem_addr);
         mem_pending    = 1'b0;
      end else begin
         bus.imemRvalid = 1'b0;
         bus.imemRdata  = $urandom;
         if (mem_pending) mem_wait = mem_wait - 1;
      end
      bus.imemGnt = 1'b0;
      #1;
      o_req    = bus.imemReq;
      o_addr   = bus.imemAddr;
      o_valid  = bus.instValid;
      o_pc     = bus.instPC;
      o_data   = bus.instData;
      o_fault  = bus.instFault;
      o_fetch  = bus.fetchPC;
      o_rvalid = bus.imemRvalid;
      o_pop    = o_valid && drv_ready && !drv_redirect;
      o_grant  = o_req && ($urandom_range(99) < gnt_pct);
      if (o_req) bus.imemGnt = o_grant;
      else       bus.imemGnt = 1'($urandom_range(1));
      if (o_grant) begin
         mem_pending = 1'b1;
         mem_addr    = o_addr;
         mem_wait    = lat_min + $urandom_range(lat_max - lat_min);
      end
      drv_redirect = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (bus.instValid !== 1'b0 || bus.instFault !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: instValid=%b instFault=%b, expected 0 0", bus.instValid, bus.instFault);
      end
      checks++;
      if (bus.fetchPC !== RST_PC) begin
         errors++;
         $display("FAIL reset_fetchpc: got %h expected %h", bus.fetchPC, RST_PC);
      end
      checks++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== RST_PC) begin
         errors++;
         $display("FAIL reset_first_req: req=%b addr=%h, expected 1 %h", bus.imemReq, bus.imemAddr, RST_PC);
      end
   endtask

   task automatic test_sequential();
      int          gc[3];
      logic [31:0] ga[3];
      int          ng = 0;
      int          first_valid = -1;
      logic [31:0] fv_pc = '0;
      int          npop = 0;
      do_reset();
      gnt_pct = 100; lat_min = 0; lat_max = 0; drv_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         if (o_grant && ng < 3) begin gc[ng] = c; ga[ng] = o_addr; ng++; end
         if (o_valid && first_valid < 0) begin first_valid = c; fv_pc = o_pc; end
         if (o_pop) begin
            npop++;
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc) || o_fault !== 1'b0) begin
               errors++;
               $display("FAIL seq_pop: pc=%h data=%h fault=%b, expected pc=%h data=%h", o_pc, o_data, o_fault, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      checks++;
      if (ng != 3) begin
         errors++;
         $display("FAIL seq_grants: got %0d grants expected 3", ng);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ga[i] !== RST_PC + 32'(4 * i) || gc[i] != gc[0] + i) begin
               errors++;
               $display("FAIL seq_req%0d: addr=%h cycle=%0d, expected addr=%h cycle=%0d", i, ga[i], gc[i], RST_PC + 32'(4 * i), gc[0] + i);
            end
         end
         checks++;
         if (first_valid != gc[0] + 2 || fv_pc !== RST_PC) begin
            errors++;
            $display("FAIL seq_latency: first valid cycle=%0d pc=%h, expected cycle=%0d pc=%h", first_valid, fv_pc, gc[0] + 2, RST_PC);
         end
      end
      checks++;
      if (npop != 10) begin
         errors++;
         $display("FAIL seq_throughput: got %0d pops expected 10", npop);
      end
   endtask

   task automatic test_stall();
      int npop = 0;
      drv_ready = 1'b0;
      repeat (8) step();
      checks++;
      if (o_req !== 1'b0 || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_full: req=%b valid=%b, expected 0 1", o_req, o_valid);
      end
      gnt_pct = 0; drv_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (o_pop) begin
            npop++;
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL stall_pop: pc=%h data=%h, expected pc=%h data=%h", o_pc, o_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      checks++;
      if (npop != DEPTH) begin
         errors++;
         $display("FAIL stall_count: got %0d buffered entries expected %0d", npop, DEPTH);
      end
      gnt_pct = 100; npop = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_pop) begin
            npop++;
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL stall_resume: pc=%h data=%h, expected pc=%h data=%h", o_pc, o_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      checks++;
      if (npop < 5) begin
         errors++;
         $display("FAIL stall_progress: got %0d pops expected at least 5", npop);
      end
   endtask

   task automatic test_redirect_outstanding();
      logic found = 1'b0;
      logic stale_seen = 1'b0;
      logic granted = 1'b0;
      do_reset();
      gnt_pct = 100; lat_min = 2; lat_max = 2; drv_ready = 1'b1;
      for (int c = 0; c < 20 && !found; c++) begin
         step();
         if (o_grant && o_addr == RST_PC + 32'h8) found = 1'b1;
         if (o_pop) exp_pc = exp_pc + 32'd4;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL redir_setup: no grant to %h seen", RST_PC + 32'h8);
         return;
      end
      drv_redirect = 1'b1; drv_target = 32'h200;
      step();
      exp_pc = 32'h200;
      checks++;
      if (o_req !== 1'b0) begin
         errors++;
         $display("FAIL redir_req: req=%b during redirect, expected 0", o_req);
      end
      for (int c = 0; c < 20 && !granted; c++) begin
         step();
         if (o_rvalid) stale_seen = 1'b1;
         if (o_grant) begin
            granted = 1'b1;
            checks++;
            if (o_addr !== 32'h200 || !stale_seen) begin
               errors++;
               $display("FAIL redir_next_req: addr=%h stale_done=%b, expected 200 1", o_addr, stale_seen);
            end
         end
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: instValid=%b pc=%h, expected 0", o_valid, o_pc);
         end
      end
      checks++;
      if (!granted) begin
         errors++;
         $display("FAIL redir_timeout: no request after redirect");
      end
      for (int c = 0; c < 12; c++) begin
         step();
         if (o_pop) begin
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL redir_stream: pc=%h data=%h, expected pc=%h data=%h", o_pc, o_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
   endtask

   task automatic test_redirect_rvalid_pop();
      do_reset();
      gnt_pct = 100; lat_min = 0; lat_max = 0; drv_ready = 1'b1;
      repeat (5) begin
         step();
         if (o_pop) exp_pc = exp_pc + 32'd4;
      end
      drv_redirect = 1'b1; drv_target = 32'h200;
      step();
      exp_pc = 32'h200;
      checks++;
      if (o_valid !== 1'b1 || o_rvalid !== 1'b1 || o_req !== 1'b0) begin
         errors++;
         $display("FAIL rvp_cycle: valid=%b rvalid=%b req=%b, expected 1 1 0", o_valid, o_rvalid, o_req);
      end
      step();
      checks++;
      if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h200) begin
         errors++;
         $display("FAIL rvp_next: valid=%b req=%b addr=%h, expected 0 1 200", o_valid, o_req, o_addr);
      end
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_pop) begin
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL rvp_stream: pc=%h data=%h, expected pc=%h data=%h", o_pc, o_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] ga[3];
      int          ng = 0;
      gnt_pct = 100; lat_min = 0; lat_max = 0; drv_ready = 1'b1;
      drv_redirect = 1'b1; drv_target = 32'hFFFF_FFF8;
      step();
      exp_pc = 32'hFFFF_FFF8;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_grant && ng < 3) begin ga[ng] = o_addr; ng++; end
         if (o_pop) begin
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL wrap_stream: pc=%h data=%h, expected pc=%h data=%h", o_pc, o_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      checks++;
      if (ng != 3 || ga[0] !== 32'hFFFF_FFF8 || ga[1] !== 32'hFFFF_FFFC || ga[2] !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_req: %0d grants %h %h %h, expected fffffff8 fffffffc 00000000", ng, ga[0], ga[1], ga[2]);
      end
   endtask

   task automatic test_reset_mid();
      gnt_pct = 100; lat_min = 2; lat_max = 3; drv_ready = 1'b1;
      repeat (6) step();
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.instValid !== 1'b0 || bus.fetchPC !== RST_PC) begin
         errors++;
         $display("FAIL rstmid_async: valid=%b fetchPC=%h, expected 0 %h", bus.instValid, bus.fetchPC, RST_PC);
      end
      @(negedge clk);
      rstn = 1'b1;
      exp_pc = RST_PC;
      // stray response with no matching grant arrives right after reset
      mem_pending = 1'b1; mem_wait = 0; mem_addr = 32'h0000_0999;
      gnt_pct = 0;
      step();
      checks++;
      if (o_req !== 1'b1 || o_addr !== RST_PC || o_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_req: req=%b addr=%h rvalid=%b, expected 1 %h 1", o_req, o_addr, o_rvalid, RST_PC);
      end
      gnt_pct = 100; lat_min = 0; lat_max = 0;
      step();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_stray: instValid=%b pc=%h, expected 0", o_valid, o_pc);
      end
      for (int c = 0; c < 8; c++) begin
         step();
         if (o_pop) begin
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL rstmid_stream: pc=%h data=%h, expected pc=%h data=%h", o_pc, o_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_fetch;
      logic        rd;
      int          npop = 0;
      do_reset();
      exp_fetch = RST_PC;
      gnt_pct = 60; lat_min = 0; lat_max = 3;
      for (int c = 0; c < 600; c++) begin
         drv_ready = ($urandom_range(99) < 70);
         rd = ($urandom_range(99) < 4);
         drv_redirect = rd;
         drv_target = $urandom & 32'hFFFF_FFFC;
         step();
         if (rd) begin
            checks++;
            if (o_req !== 1'b0) begin
               errors++;
               $display("FAIL rnd_redir_req: req=%b during redirect, expected 0", o_req);
            end
            exp_pc = drv_target;
            exp_fetch = drv_target;
         end
         if (o_grant) begin
            checks++;
            if (o_addr !== exp_fetch) begin
               errors++;
               $display("FAIL rnd_req_addr: addr=%h expected %h", o_addr, exp_fetch);
            end
            exp_fetch = exp_fetch + 32'd4;
         end
         if (o_pop) begin
            npop++;
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc) || o_fault !== 1'b0) begin
               errors++;
               $display("FAIL rnd_pop: pc=%h data=%h fault=%b, expected pc=%h data=%h", o_pc, o_data, o_fault, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      checks++;
      if (npop < 100) begin
         errors++;
         $display("FAIL rnd_progress: got %0d pops expected at least 100", npop);
      end
   endtask

   task automatic test_misalign();
      int   npop = 0;
      logic saw_req = 1'b0;
      do_reset();
      gnt_pct = 100; lat_min = 2; lat_max = 2; drv_ready = 1'b1;
      repeat (6) begin
         step();
         if (o_pop) exp_pc = exp_pc + 32'd4;
      end
      drv_redirect = 1'b1; drv_target = 32'h302;
      step();
`ifdef FETCH_MISALIGN_CHECK_EN
      for (int c = 0; c < 20; c++) begin
         step();
         if (o_req) saw_req = 1'b1;
         if (o_pop) begin
            npop++;
            checks++;
            if (o_pc !== 32'h302 || o_data !== 32'h0 || o_fault !== 1'b1) begin
               errors++;
               $display("FAIL mis_entry: pc=%h data=%h fault=%b, expected 302 0 1", o_pc, o_data, o_fault);
            end
         end
      end
      checks++;
      if (saw_req || npop != 1) begin
         errors++;
         $display("FAIL mis_halt: req_seen=%b entries=%0d, expected 0 1", saw_req, npop);
      end
      drv_redirect = 1'b1; drv_target = 32'h400;
      step();
      exp_pc = 32'h400;
`else
      exp_pc = 32'h300;
`endif
      npop = 0;
      for (int c = 0; c < 14; c++) begin
         step();
         if (o_pop) begin
            npop++;
            checks++;
            if (o_pc !== exp_pc || o_data !== mem_word(exp_pc) || o_fault !== 1'b0) begin
               errors++;
               $display("FAIL mis_stream: pc=%h data=%h fault=%b, expected pc=%h data=%h fault=0", o_pc, o_data, o_fault, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      checks++;
      if (npop < 2) begin
         errors++;
         $display("FAIL mis_resume: got %0d pops expected at least 2", npop);
      end
   endtask

   initial begin
      rstn = 1'b0;
      drv_ready = 1'b0; gnt_pct = 0; lat_min = 0; lat_max = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_outstanding();
      test_redirect_rvalid_pop();
      test_wrap();
      test_reset_mid();
      test_random();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
